im_pipelined: RTL and testbench

Parametrised instruction memory for the multi-cycle MIPS datapath: word-addressed synchronous ROM-style store with a configurable-latency, fully pipelined read port and a sequential program-load port that replaces file-based initialisation. Sits between the PC/IR logic and the rest of the datapath. Gives testbenches and future SoC wrappers a deterministic way to fill the store at run time, and flags misaligned fetches.

---
 rtl/im_pipelined.sv | 78 +++++++
 tb/tb_im_pipelined.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/im_pipelined.sv
// im_pipelined: word-addressed instruction memory with a fixed-latency pipelined
// read port and a sequential program-load port.
module im_pipelined #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W+1:0] addr,
  input  logic              rd_req,
  output logic              rd_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              misalign,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic [ADDR_W:0]   ld_ptr,
  output logic              ld_full,
  output logic              ld_ovf
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {RUN, LOAD} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pd [LATENCY];
  logic pv [LATENCY];
  logic pm [LATENCY];
  logic acc, we;
  assign rd_ready = state == RUN;
  assign ld_full = ld_ptr == (ADDR_W+1)'(DEPTH);
  assign acc = rd_req && rd_ready;
  // ld_start restarts the load, so a write in that same cycle is dropped
  assign we = rst_n && state == LOAD && ld_valid && !ld_full && !ld_start;
  always_ff @(posedge clk)
    if (we) mem[ld_ptr[ADDR_W-1:0]] <= ld_data;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state  <= RUN;
      ld_ptr <= '0;
      ld_ovf <= 1'b0;
    end else if (ld_start) begin
      state  <= LOAD;
      ld_ptr <= '0;
      ld_ovf <= 1'b0;
    end else if (state == LOAD) begin
      if (ld_valid && ld_full) ld_ovf <= 1'b1;
      if (we) ld_ptr <= ld_ptr + (ADDR_W+1)'(1);
      if (ld_done) state <= RUN;
    end
  // data stages only advance behind a valid, so dout holds between fetches
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv[i] <= 1'b0;
        pm[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= acc;
      if (acc) begin
        pd[0] <= mem[addr[ADDR_W+1:2]];
        pm[0] <= |addr[1:0];
      end
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
          pm[i] <= pm[i-1];
        end
      end
    end
  assign dout       = pd[LATENCY-1];
  assign dout_valid = pv[LATENCY-1];
  assign misalign   = pv[LATENCY-1] && pm[LATENCY-1];
endmodule

// File: tb/tb_im_pipelined.sv
// tb_im_pipelined: four instances (LATENCY 1..4, ADDR_W=4) on shared stimulus,
// checked each cycle against a history-based model plus literal expectations.
module tb_im_pipelined;
  localparam int AW = 4;
  localparam int NH = 4096;
  logic clk = 0;
  logic rst_n = 0;
  logic [AW+1:0] addr = '0;
  logic rd_req = 0, ld_start = 0, ld_valid = 0, ld_done = 0;
  logic [31:0] ld_data = '0;
  logic rdy [4];
  logic [31:0] dout [4];
  logic dv [4];
  logic mis [4];
  logic [AW:0] ptr [4];
  logic full [4];
  logic ovf [4];
  int tests = 0, fails = 0, cyc = 0;
  bit mload = 0;
  int mptr = 0;
  bit movf = 0;
  logic [31:0] mm [16];
  bit hacc [NH];
  logic [31:0] hdat [NH];
  bit hmis [NH];
  bit hrst [NH];
  logic [31:0] exp_d [4];
  bit exp_v [4];
  bit exp_m [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    im_pipelined #(.ADDR_W(AW), .DATA_W(32), .LATENCY(g + 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .rd_req(rd_req), .rd_ready(rdy[g]),
      .dout(dout[g]), .dout_valid(dv[g]), .misalign(mis[g]),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_done(ld_done),
      .ld_ptr(ptr[g]), .ld_full(full[g]), .ld_ovf(ovf[g]));
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", n, cyc, a, e);
    end
  endtask

  task automatic tick();
    int src;
    bit ok;
    hacc[cyc] = rst_n && rd_req && !mload;
    hdat[cyc] = mm[addr[AW+1:2]];
    hmis[cyc] = addr[1:0] != 2'b00;
    hrst[cyc] = !rst_n;
    if (!rst_n) begin
      mload = 0; mptr = 0; movf = 0;
    end else if (ld_start) begin
      mload = 1; mptr = 0; movf = 0;
    end else if (mload) begin
      if (ld_valid) begin
        if (mptr == 16) movf = 1;
        else begin
          mm[mptr] = ld_data;
          mptr++;
        end
      end
      if (ld_done) mload = 0;
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < 4; l++) begin
      src = cyc - l;
      ok = src >= 0 && hacc[src];
      for (int j = src + 1; j <= cyc; j++) if (ok && hrst[j]) ok = 0;
      if (hrst[cyc]) begin
        exp_d[l] = '0; exp_v[l] = 0; exp_m[l] = 0;
      end else begin
        exp_v[l] = ok;
        exp_m[l] = ok && hmis[src];
        if (ok) exp_d[l] = hdat[src];
      end
      chk($sformatf("dout_valid L%0d", l + 1), 64'(dv[l]), 64'(exp_v[l]));
      chk($sformatf("dout L%0d", l + 1), 64'(dout[l]), 64'(exp_d[l]));
      chk($sformatf("misalign L%0d", l + 1), 64'(mis[l]), 64'(exp_m[l]));
      chk($sformatf("rd_ready L%0d", l + 1), 64'(rdy[l]), 64'(!mload));
      chk($sformatf("ld_ptr L%0d", l + 1), 64'(ptr[l]), 64'(mptr));
      chk($sformatf("ld_full L%0d", l + 1), 64'(full[l]), 64'(mptr == 16));
      chk($sformatf("ld_ovf L%0d", l + 1), 64'(ovf[l]), 64'(movf));
    end
    cyc++;
  endtask

  initial begin
    for (int l = 0; l < 4; l++) begin
      exp_d[l] = '0; exp_v[l] = 0; exp_m[l] = 0;
    end
    tick();
    tick();
    chk("reset rd_ready", 64'(rdy[0]), 64'd1);
    chk("reset dout", 64'(dout[3]), 64'd0);
    chk("reset ld_ptr", 64'(ptr[1]), 64'd0);
    rst_n = 1;
    ld_start = 1; tick(); ld_start = 0;
    chk("load rd_ready low", 64'(rdy[1]), 64'd0);
    ld_valid = 1;
    ld_data = 32'h20080005; tick();
    ld_data = 32'h2009000A; tick();
    ld_data = 32'h01095020; tick();
    ld_valid = 0;
    ld_done = 1; tick(); ld_done = 0;
    chk("loaded ptr", 64'(ptr[1]), 64'd3);
    rd_req = 1; addr = 6'h00; tick();
    chk("L2 not yet", 64'(dv[1]), 64'd0);
    addr = 6'h04; tick();
    chk("L2 word0", 64'(dout[1]), 64'h20080005);
    chk("L2 valid0", 64'(dv[1]), 64'd1);
    addr = 6'h08; tick();
    chk("L2 word1", 64'(dout[1]), 64'h2009000A);
    rd_req = 0; tick();
    chk("L2 word2", 64'(dout[1]), 64'h01095020);
    tick();
    chk("L2 hold", 64'(dout[1]), 64'h01095020);
    chk("L2 pulse end", 64'(dv[1]), 64'd0);
    rd_req = 1; addr = 6'h06; tick(); rd_req = 0; tick();
    chk("misalign data", 64'(dout[1]), 64'h2009000A);
    chk("misalign flag", 64'(mis[1]), 64'd1);
    ld_start = 1; tick(); ld_start = 0;
    ld_valid = 1;
    for (int i = 0; i < 17; i++) begin
      ld_data = 32'h100 + 32'(i); tick();
    end
    ld_valid = 0;
    chk("ovf ptr", 64'(ptr[0]), 64'd16);
    chk("ovf full", 64'(full[0]), 64'd1);
    chk("ovf sticky", 64'(ovf[0]), 64'd1);
    ld_done = 1; tick(); ld_done = 0;
    rd_req = 1; addr = 6'h00; tick(); rd_req = 0;
    chk("word0 kept", 64'(dout[0]), 64'h100);
    ld_start = 1; tick(); ld_start = 0;
    chk("restart ptr", 64'(ptr[0]), 64'd0);
    chk("restart ovf", 64'(ovf[0]), 64'd0);
    ld_done = 1; tick(); ld_done = 0;
    rd_req = 1; addr = 6'h00; ld_start = 1; tick(); ld_start = 0;
    rd_req = 0; ld_valid = 1; ld_data = 32'hDEADBEEF; tick(); ld_valid = 0;
    rd_req = 1; tick();
    chk("inflight old", 64'(dout[2]), 64'h100);
    chk("inflight valid", 64'(dv[2]), 64'd1);
    tick(); tick(); tick();
    chk("load no valid", 64'(dv[2]), 64'd0);
    rd_req = 0; ld_done = 1; tick(); ld_done = 0;
    rd_req = 1; addr = 6'h00; tick(); rd_req = 0;
    tick();
    rst_n = 0; tick();
    chk("rst discard a", 64'(dv[3]), 64'd0);
    tick();
    chk("rst discard b", 64'(dv[3]), 64'd0);
    rst_n = 1; tick();
    chk("rst discard c", 64'(dv[3]), 64'd0);
    rd_req = 1; tick(); rd_req = 0;
    tick(); tick(); tick();
    chk("post rst data", 64'(dout[3]), 64'hDEADBEEF);
    chk("post rst valid", 64'(dv[3]), 64'd1);
    for (int i = 0; i < 2000; i++) begin
      rst_n    = $urandom_range(99) != 0;
      rd_req   = $urandom_range(1);
      addr     = 6'($urandom);
      ld_start = $urandom_range(32) == 0;
      ld_done  = $urandom_range(9) == 0;
      ld_valid = $urandom_range(1);
      ld_data  = $urandom;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
